// File: rtl/ct_f_spsram_access_ctrl.sv
// Single-port SRAM initiator: post-reset init sweep, valid/ready request stream to
// active-low SRAM strobes, read data returned through a credit-guarded response FIFO.
module ct_f_spsram_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter bit          INIT_EN    = 1'b1,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwen,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1) + 1;
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] INIT_DATA = DATA_WIDTH'(INIT_VALUE);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         occ;
  logic                  run;
  logic                  pop;
  logic                  push;
  logic                  acc;
  logic                  wr_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits count both FIFO entries and the read still in flight through the SRAM.
  always_comb begin
    run       = (state == ST_RUN) && !RST;
    init_done = run;
    rsp_vld   = run && (fifo_cnt != '0);
    rsp_rdata = fifo[rd_ptr];
    pop       = rsp_vld && rsp_rdy;
    push      = rd_pend;
    occ       = fifo_cnt + CW'(rd_pend) - CW'(pop);
    req_rdy   = run && (occ < CW'(RSP_DEPTH));
    acc       = req_vld && req_rdy;
    wr_acc    = acc && req_wr;
  end

  always_comb begin
    A    = req_addr;
    D    = req_wdata;
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    if (!RST && state == ST_INIT) begin
      A    = init_cnt;
      D    = INIT_DATA;
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
    end else if (run) begin
      CEN  = !acc;
      GWEN = !wr_acc;
      WEN  = wr_acc ? ~req_bwen : '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt <= '0;
      rd_pend  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (&init_cnt) state <= ST_RUN;
          else           init_cnt <= init_cnt + 1'b1;
        end
        ST_RUN: begin
          rd_pend <= acc && !req_wr;
          if (push) wr_ptr <= ptr_inc(wr_ptr);
          if (pop)  rd_ptr <= ptr_inc(rd_ptr);
          fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Q is valid the cycle after the read strobe, i.e. while rd_pend is set.
  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= Q;
  end

endmodule

// File: tb/tb_ct_f_spsram_access_ctrl.sv
// Bench for ct_f_spsram_access_ctrl: behavioural SRAM, request-level reference model,
// directed vector table, multi-cycle corner sequences and a randomized phase.
module tb_ct_f_spsram_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RD = 2;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          init_done, req_vld, req_rdy, req_wr, rsp_vld, rsp_rdy, CEN, GWEN;
  logic [AW-1:0] req_addr, A;
  logic [DW-1:0] req_wdata, req_bwen, rsp_rdata, WEN, D, Q;

  ct_f_spsram_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(RD), .INIT_EN(1'b1), .INIT_VALUE(0)
  ) dut (
    .CLK(CLK), .RST(RST), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bwen(req_bwen),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM: 1-cycle read latency, Q holds across writes.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q <= mem[A];
    end
  end

  // Reference model: expected contents and outstanding reads with their accept cycle.
  typedef struct { logic [DW-1:0] data; int cyc; } pend_t;
  pend_t         q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] last_rsp;
  int cyc = 0, init_left = DEPTH;
  int n_acc = 0, n_pop = 0, last_acc_cyc = 0, last_pop_cyc = 0;
  int n_cmp = 0, n_fail = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Inputs are driven at posedge+1; outputs checked at posedge+2; returns at posedge+1.
  task automatic tick();
    bit ev, er, pop, acc;
    #1;
    if (RST) begin
      chk("rst_cen", CEN, 1); chk("rst_gwen", GWEN, 1); chk("rst_wen", WEN, '1);
      chk("rst_req_rdy", req_rdy, 0); chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_init_done", init_done, 0);
    end else if (init_left > 0) begin
      chk("init_cen", CEN, 0); chk("init_gwen", GWEN, 0); chk("init_wen", WEN, '0);
      chk("init_a", A, DEPTH - init_left); chk("init_d", D, 0);
      chk("init_req_rdy", req_rdy, 0); chk("init_rsp_vld", rsp_vld, 0);
      chk("init_done_low", init_done, 0);
    end else begin
      ev = q.size() > 0 && (cyc - q[0].cyc >= 2);
      er = (q.size() - ((ev && rsp_rdy) ? 1 : 0)) < RD;
      chk("init_done", init_done, 1);
      chk("rsp_vld", rsp_vld, ev);
      chk("req_rdy", req_rdy, er);
      pop = ev && rsp_rdy;
      acc = req_vld && er;
      if (pop) begin
        chk("rsp_rdata", rsp_rdata, q[0].data);
        last_rsp = rsp_rdata; got_q.push_back(rsp_rdata);
        last_pop_cyc = cyc; n_pop++;
        void'(q.pop_front());
      end
      chk("cen", CEN, !acc);
      if (acc) begin
        chk("a", A, req_addr);
        n_acc++; last_acc_cyc = cyc;
        if (req_wr) begin
          chk("gwen_wr", GWEN, 0); chk("wen_wr", WEN, ~req_bwen); chk("d_wr", D, req_wdata);
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_bwen) | (req_wdata & req_bwen);
        end else begin
          chk("gwen_rd", GWEN, 1);
          q.push_back('{ref_mem[req_addr], cyc});
        end
      end else begin
        chk("gwen_idle", GWEN, 1);
      end
    end
    @(posedge CLK);
    if (RST) begin
      q.delete(); init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end
    cyc++;
    #1;
  endtask

  task automatic reset_and_init(input int cycles);
    int n;
    RST = 1'b1; req_vld = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    RST = 1'b0;
    n = 0;
    while (!init_done && n < 40) begin tick(); n++; end
    chk("init_len", n, DEPTH);
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] bwen);
    int a0 = n_acc;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_bwen = bwen;
    for (int k = 0; k < 20 && n_acc == a0; k++) tick();
    chk("accept", n_acc - a0, 1);
    req_vld = 1'b0;
  endtask

  typedef struct {
    bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] bwen; logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int base, pbase, p0;
    req_vld = 0; req_wr = 0; req_addr = '0; req_wdata = '0; req_bwen = '0; rsp_rdy = 1;
    vecs[0] = '{1'b1, 4'd5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0};
    vecs[1] = '{1'b0, 4'd5, 32'h0,         32'h0,         32'hA5A5_A5A5};
    vecs[2] = '{1'b0, 4'd6, 32'h0,         32'h0,         32'h0};
    vecs[3] = '{1'b1, 4'd3, 32'hFFFF_FFFF, 32'h0000_00FF, 32'h0};
    vecs[4] = '{1'b0, 4'd3, 32'h0,         32'h0,         32'h0000_00FF};
    vecs[5] = '{1'b0, 4'd15, 32'h0,        32'h0,         32'h0};

    @(posedge CLK); #1;
    reset_and_init(2);

    // Directed table: writes, masked write, reads with expected data and 2-cycle latency.
    foreach (vecs[i]) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bwen);
      if (!vecs[i].wr) begin
        p0 = n_pop;
        for (int k = 0; k < 10 && n_pop == p0; k++) tick();
        chk("vec_rsp_seen", n_pop - p0, 1);
        chk("vec_latency", last_pop_cyc - last_acc_cyc, 2);
        chk("vec_data", last_rsp, vecs[i].exp);
      end
    end

    // Backpressure: only RSP_DEPTH reads accepted while rsp_rdy=0, then in-order drain.
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), 32'h100 + i, '1);
    tick(); tick();
    rsp_rdy = 1'b0; base = n_acc; got_q.delete();
    for (int k = 0; k < 6; k++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(n_acc - base); tick();
    end
    chk("bp_accepted", n_acc - base, 2);
    chk("bp_req_rdy", req_rdy, 0);
    rsp_rdy = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < 4; k++) begin
      req_vld = (n_acc - base) < 4; req_addr = AW'(n_acc - base); tick();
    end
    req_vld = 1'b0;
    chk("bp_rsp_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("bp_order", got_q[i], 32'h100 + i);

    // Streaming: 8 back-to-back reads, one accept and one response per cycle.
    tick(); tick();
    base = n_acc; pbase = n_pop;
    for (int i = 0; i < 8; i++) begin
      req_vld = 1'b1; req_wr = 1'b0; req_addr = AW'(i); tick();
    end
    req_vld = 1'b0;
    chk("stream_accepts", n_acc - base, 8);
    chk("stream_rsp_mid", n_pop - pbase, 6);
    tick(); tick();
    chk("stream_rsp_all", n_pop - pbase, 8);

    // Reset with a full credit window (one in FIFO, one in flight): nothing survives.
    rsp_rdy = 1'b0; base = n_acc;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
    for (int k = 0; k < 10 && n_acc - base < 2; k++) tick();
    chk("pre_rst_accepts", n_acc - base, 2);
    reset_and_init(1);
    rsp_rdy = 1'b1; p0 = n_pop;
    for (int k = 0; k < 5; k++) tick();
    chk("no_stale_rsp", n_pop - p0, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      req_vld   = ($urandom % 4) != 0;
      req_wr    = $urandom % 2;
      req_addr  = AW'($urandom % DEPTH);
      req_wdata = $urandom;
      req_bwen  = ($urandom % 2) ? '1 : DW'($urandom);
      rsp_rdy   = ($urandom % 4) != 0;
      tick();
    end
    req_vld = 1'b0; rsp_rdy = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
